// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader's view of these signals; the master modport is the host's view.
interface imem_program_loader_if #(
    parameter int LEN_W = 7
);
    logic             start;
    logic [LEN_W-1:0] prog_len;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, prog_len, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport slave (
        input  start, prog_len, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: packs a little-endian byte stream into
// 32-bit words and writes them at consecutive word-aligned addresses from 0.
module imem_program_loader #(
    parameter int DEPTH = 64,
    parameter int LEN_W = 7
) (
    input logic                  clk,
    input logic                  reset,
    imem_program_loader_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [1:0]       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [31:0]      shift;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             done;
    logic             err;

    // NOTE: every register in this block uses <= so all next-state values are computed from the
    // same pre-edge snapshot; a blocking = here would let later lines see half-updated state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.prog_len == '0) begin
                            done <= 1'b1;
                        end else if (bus.prog_len > DEPTH_L) begin
                            err <= 1'b1;
                        end else begin
                            len      <= bus.prog_len;
                            done     <= 1'b0;
                            word_idx <= '0;
                            byte_idx <= '0;
                            shift    <= '0;
                            state    <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid) begin
                        // Shift right so the first byte received ends up in bits [7:0].
                        shift    <= {bus.byte_in, shift[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {{(30-LEN_W){1'b0}}, word_idx, 2'b00};
                            mem_wdata <= {bus.byte_in, shift[31:8]};
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (word_idx == len - 1'b1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        state    <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = (state == COLLECT);
    assign bus.busy       = (state != IDLE);
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.done       = done;
    assign bus.err        = err;
endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: expected writes are queued as bytes are sent
// and popped by a monitor on every mem_we pulse.
module tb_imem_program_loader;
    logic clk;
    logic reset;

    imem_program_loader_if #(.LEN_W(7)) bus ();

    imem_program_loader #(.DEPTH(64), .LEN_W(7)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int write_count = 0;
    logic [63:0] exp_q[$];

    // Monitor: sample on the falling edge, compare each write with the oldest expectation.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            logic [63:0] e;
            write_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write_content: got addr=%h data=%h, expected addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, e[63:32], e[31:0]);
                end
            end
            tests++;
            if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL write_cycle_flags: got byte_ready=%b busy=%b, expected 0/1",
                         bus.byte_ready, bus.busy);
            end
        end
    end

    task automatic do_start(input logic [6:0] len);
        bus.start    = 1'b1;
        bus.prog_len = len;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int   cnt;
        repeat (gap) begin @(posedge clk); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        cnt = 0;
        do begin
            @(negedge clk);
            r = bus.byte_ready;
            @(posedge clk); #1;
            cnt++;
        end while (r !== 1'b1 && cnt < 50);
        bus.byte_valid = 1'b0;
        if (r !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: got byte_ready=%b, expected 1 within 50 cycles", r);
        end
    endtask

    task automatic send_word(input logic [6:0] idx, input logic [31:0] data, input int max_gap);
        exp_q.push_back({{23'b0, idx, 2'b00}, data});
        for (int k = 0; k < 4; k++)
            send_byte(data[8*k +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: got done=%b busy=%b, expected 1/0", name, bus.done, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string name, input int base, input int nwrites);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (write_count - base != nwrites || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_write_count: got %0d writes (%0d pending), expected %0d",
                     name, write_count - base, exp_q.size(), nwrites);
        end
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b0;
        bus.start = 1'b0; bus.prog_len = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, expected all 0",
                     bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err);
        end
        reset = 1'b1;
        base = write_count;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs: got rdy=%b busy=%b done=%b, expected 0/0/0",
                         bus.byte_ready, bus.busy, bus.done);
            end
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        check_drained("idle", base, 0);
    endtask

    task automatic test_zero_len();
        int base = write_count;
        do_start(7'd0);
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_done: got done=%b busy=%b, expected 1/0", bus.done, bus.busy);
        end
        check_drained("zero_len", base, 0);
    endtask

    task automatic test_single_word();
        int base = write_count;
        do_start(7'd1);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL single_start: got done=%b busy=%b, expected 0/1", bus.done, bus.busy);
        end
        send_word(7'd0, 32'h006283B3, 0);
        @(negedge clk);
        tests++;
        if (bus.mem_we !== 1'b1) begin
            fails++;
            $display("FAIL single_write_latency: got mem_we=%b, expected 1 one cycle after byte 4", bus.mem_we);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got done=%b busy=%b, expected 1/0", bus.done, bus.busy);
        end
        check_drained("single", base, 1);
    endtask

    task automatic test_multi_stall();
        int base = write_count;
        do_start(7'd3);
        for (int w = 0; w < 3; w++) send_word(7'(w), $urandom, 3);
        wait_done("multi", 20);
        check_drained("multi", base, 3);
    endtask

    task automatic test_bounds();
        int base = write_count;
        do_start(7'd64);
        for (int w = 0; w < 64; w++) send_word(7'(w), $urandom, 0);
        wait_done("len64", 20);
        check_drained("len64", base, 64);

        base = write_count;
        bus.start = 1'b1; bus.prog_len = 7'd65;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL len65_err: got err=%b busy=%b done=%b, expected 1/0/1", bus.err, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL len65_err_pulse: got err=%b busy=%b, expected 0/0", bus.err, bus.busy);
        end
        check_drained("len65", base, 0);
    endtask

    task automatic test_ignored_start();
        int base = write_count;
        logic [31:0] d0 = $urandom;
        do_start(7'd2);
        exp_q.push_back({32'h0, d0});
        send_byte(d0[7:0], 0);
        send_byte(d0[15:8], 0);
        do_start(7'd5);
        tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL ignored_start_flags: got err=%b busy=%b, expected 0/1", bus.err, bus.busy);
        end
        send_byte(d0[23:16], 0);
        send_byte(d0[31:24], 0);
        send_word(7'd1, $urandom, 0);
        wait_done("ignored_start", 20);
        check_drained("ignored_start", base, 2);
    endtask

    task automatic test_reset_mid();
        int base = write_count;
        logic [31:0] d0 = $urandom;
        do_start(7'd2);
        send_word(7'd0, d0, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err} !== '0) begin
            fails++;
            $display("FAIL async_reset_outputs: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, expected all 0",
                     bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_start(7'd1);
        send_word(7'd0, 32'hCAFEF00D, 1);
        wait_done("reset_mid", 20);
        check_drained("reset_mid", base, 2);
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_single_word();
        test_multi_stall();
        test_bounds();
        test_ignored_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
